// File: rtl/bec_la_bridge.sv
// LA-probe bridge to the BEC core: word-serial operand load, one start pulse, word-serial result readback; all outputs registered.
// Both directions are 4-phase handshakes paced by firmware; optional core-done watchdog under BEC_LA_TIMEOUT_EN.
module bec_la_bridge #(
  parameter int DATA_W      = 163,
  parameter int WORD_W      = 32,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              wb_clk_i,
  input  logic              wb_rstn_i,
  input  logic [WORD_W-1:0] la_word_i,
  input  logic              la_valid_i,
  output logic              la_ack_o,
  input  logic              la_rd_req_i,
  output logic              la_rd_ack_o,
  output logic [WORD_W-1:0] la_word_o,
  output logic [DATA_W-1:0] core_data_o,
  output logic              core_start_o,
  input  logic              core_done_i,
  input  logic [DATA_W-1:0] core_result_i,
  output logic [15:0]       status_o
);

  localparam int NW = (DATA_W + WORD_W - 1) / WORD_W;
  localparam int XW = (NW > 1) ? $clog2(NW) : 1;
  localparam int PW = $clog2(NW * WORD_W);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_BUSY, S_SEND, S_DONE, S_FAIL
  } state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                ack_q, ack_d;
  logic                rd_ack_q, rd_ack_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                start_q, start_d;
  logic [15:0]         status_q, status_d;
  logic [PW-1:0]       wpos, rpos;
`ifdef BEC_LA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0]       tmo_q, tmo_d;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_d     = op_q;
    res_d    = res_q;
    ack_d    = ack_q;
    rd_ack_d = rd_ack_q;
    start_d  = 1'b0;
    wpos     = '0;
    rpos     = '0;
`ifdef BEC_LA_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    case (state_q)
      S_IDLE, S_LOAD, S_DONE, S_FAIL: begin
        if (la_valid_i && !ack_q) begin
          // Bits of the last slot beyond DATA_W have no home and are dropped.
          for (int b = 0; b < WORD_W; b++) begin
            wpos = PW'(idx_q) * PW'(WORD_W) + PW'(b);
            if (int'(wpos) < DATA_W) op_d[wpos] = la_word_i[b];
          end
          if (state_q == S_DONE || state_q == S_FAIL) res_d = '0;
          ack_d   = 1'b1;
          state_d = S_LOAD;
        end else if (!la_valid_i && ack_q) begin
          ack_d = 1'b0;
          if (idx_q == XW'(NW - 1)) begin
            idx_d   = '0;
            state_d = S_START;
            start_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_START: begin
        state_d = S_BUSY;
`ifdef BEC_LA_TIMEOUT_EN
        tmo_d = '0;
`endif
      end
      S_BUSY: begin
        if (core_done_i) begin
          res_d   = core_result_i;
          idx_d   = '0;
          state_d = S_SEND;
        end
`ifdef BEC_LA_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d = S_FAIL;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_SEND: begin
        if (la_rd_req_i && !rd_ack_q) begin
          rd_ack_d = 1'b1;
        end else if (!la_rd_req_i && rd_ack_q) begin
          rd_ack_d = 1'b0;
          if (idx_q == XW'(NW - 1)) begin
            idx_d   = '0;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Read word is built from next-state values so it is registered yet already valid on SEND entry.
    word_d = '0;
    if (state_d == S_SEND) begin
      for (int b = 0; b < WORD_W; b++) begin
        rpos = PW'(idx_d) * PW'(WORD_W) + PW'(b);
        if (int'(rpos) < DATA_W) word_d[b] = res_d[rpos];
      end
    end

    case (state_d)
      S_IDLE:          status_d = 16'hAB40;
      S_LOAD:          status_d = 16'hAB41;
      S_START, S_BUSY: status_d = 16'hAB42;
      S_SEND:          status_d = 16'hAB51;
      S_DONE:          status_d = 16'hAB43;
      S_FAIL:          status_d = 16'hAB44;
      default:         status_d = 16'hAB40;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      op_q     <= '0;
      res_q    <= '0;
      ack_q    <= 1'b0;
      rd_ack_q <= 1'b0;
      word_q   <= '0;
      start_q  <= 1'b0;
      status_q <= 16'hAB40;
`ifdef BEC_LA_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      res_q    <= res_d;
      ack_q    <= ack_d;
      rd_ack_q <= rd_ack_d;
      word_q   <= word_d;
      start_q  <= start_d;
      status_q <= status_d;
`ifdef BEC_LA_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign la_ack_o     = ack_q;
  assign la_rd_ack_o  = rd_ack_q;
  assign la_word_o    = word_q;
  assign core_data_o  = op_q;
  assign core_start_o = start_q;
  assign status_o     = status_q;

endmodule
